trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/analyzer_pkg.sv | 37 +++
 rtl/capture_ram.sv | 26 ++
 rtl/trigger_capture.sv | 158 +++++++++++++++
 tb/tb_trigger_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/analyzer_pkg.sv
// Shared logic-analyzer definitions: capture FSM state codes and trigger comparator codes.
// Imported by the capture front end and by the comparator that produces trig.
package analyzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } cap_state_e;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_GT = 3'd3,
    CMP_LE = 3'd4,
    CMP_GE = 3'd5
  } cmp_op_e;

  localparam int CMP_VAL_W = 8;
  typedef logic [CMP_VAL_W-1:0] cmp_val_t;

  function automatic logic cmp_match(input cmp_op_e op, input cmp_val_t a, input cmp_val_t b);
    case (op)
      CMP_EQ:  cmp_match = (a == b);
      CMP_NE:  cmp_match = (a != b);
      CMP_LT:  cmp_match = (a < b);
      CMP_GT:  cmp_match = (a > b);
      CMP_LE:  cmp_match = (a <= b);
      CMP_GE:  cmp_match = (a >= b);
      default: cmp_match = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port DEPTH x WIDTH sample store: synchronous write, registered read.
// Read data appears one cycle after re; no backpressure, contents are not reset.
module capture_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger circular capture with chronological readout; rd_data lags rd_en by one cycle.
// Optional CAPTURE_FORCE_TRIG_EN adds force_trig, ORed with trig while waiting for the trigger.
module trigger_capture
  import analyzer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DEPTH_LOG2-1:0] pre_len,
  input  logic [WIDTH-1:0]      sample_in,
  input  logic                  trig,
`ifdef CAPTURE_FORCE_TRIG_EN
  input  logic                  force_trig,
`endif
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_addr
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t PTR_MAX = '1;

  cap_state_e state_q, state_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       plen_q, plen_d;
  ptr_t       post_cnt_q, post_cnt_d;
  ptr_t       trig_addr_q, trig_addr_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ram_we, ram_re;
  logic       trig_hit;
  ptr_t       rd_base;

`ifdef CAPTURE_FORCE_TRIG_EN
  assign trig_hit = trig | force_trig;
`else
  assign trig_hit = trig;
`endif

  // Oldest sample of the capture window; readout starts and wraps here.
  assign rd_base = trig_addr_q - plen_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    plen_d      = plen_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          plen_d   = pre_len;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = (pre_len == '0) ? ST_WAIT : ST_PRE;
        end else if (state_q == ST_DONE && rd_en) begin
          ram_re     = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          rd_valid_d = 1'b1;
          rd_last_d  = ((rd_ptr_q + PTR_ONE) == rd_base);
        end
      end
      ST_PRE: begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (wr_ptr_q == plen_q - PTR_ONE) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (trig_hit) begin
          trig_addr_d = wr_ptr_q;
          post_cnt_d  = PTR_MAX - plen_q;
          if (post_cnt_d == '0) begin
            state_d  = ST_DONE;
            rd_ptr_d = wr_ptr_q - plen_q;
          end else begin
            state_d = ST_POST;
          end
        end
      end
      ST_POST: begin
        ram_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        post_cnt_d = post_cnt_q - PTR_ONE;
        if (post_cnt_q == PTR_ONE) begin
          state_d  = ST_DONE;
          rd_ptr_d = rd_base;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      plen_q      <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      plen_q      <= plen_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  capture_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (sample_in),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture (WIDTH=8, DEPTH_LOG2=4): directed table, corner sequences, random captures.
module tb_trigger_capture;
  localparam int WIDTH = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int NS    = 128;

  logic             clk = 1'b0;
  logic             rst, start, trig, rd_en;
  logic [DL2-1:0]   pre_len;
  logic [WIDTH-1:0] sample_in;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, rd_last, busy, done;
  logic [DL2-1:0]   trig_addr;
`ifdef CAPTURE_FORCE_TRIG_EN
  logic             force_trig;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] s_arr [NS];
  bit               t_arr [NS];
  logic [WIDTH-1:0] exp_rd [DEPTH];
  bit               force_mode;

  typedef struct {
    int pre;
    int tlo;
    int thi;
    int exp_ta;
    int exp_first;
    int exp_writes;
  } vec_t;
  vec_t vecs [6];

  trigger_capture #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pre_len   (pre_len),
    .sample_in (sample_in),
    .trig      (trig),
`ifdef CAPTURE_FORCE_TRIG_EN
    .force_trig(force_trig),
`endif
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reads DEPTH+3 samples with random gaps, so the second pass wraps and repeats.
  task automatic do_readout(input string name);
    int   reads = 0;
    int   cyc   = 0;
    logic en;
    while (reads < DEPTH + 3 && cyc < 200) begin
      en    = ($urandom_range(0, 3) != 0);
      rd_en = en;
      step();
      cyc++;
      if (en) begin
        chk({name, "_rd"}, int'({rd_valid, rd_last, rd_data}),
            int'({1'b1, 1'(reads % DEPTH == DEPTH - 1), exp_rd[reads % DEPTH]}));
        reads++;
      end else begin
        chk({name, "_rd_gap"}, int'(rd_valid), 0);
      end
    end
    rd_en = 1'b0;
    chk({name, "_rd_count"}, reads, DEPTH + 3);
    step();
    chk({name, "_rd_stop"}, int'(rd_valid), 0);
  endtask

  // Start (with rd_en also high, so start must win), stream s_arr/t_arr until done, then read back.
  task automatic do_capture(input string name, input int p, input int bogus_i,
                            input int exp_ta, input int exp_writes);
    int n    = -1;
    int vcnt = 0;
    start   = 1'b1;
    pre_len = DL2'(p);
    rd_en   = 1'b1;
    trig    = 1'b1;
    step();
    start = 1'b0;
    rd_en = 1'b0;
    chk({name, "_start"}, int'({busy, done, rd_valid}), 4);
    for (int i = 0; i < NS; i++) begin
      sample_in = s_arr[i];
      trig      = force_mode ? 1'b0 : t_arr[i];
`ifdef CAPTURE_FORCE_TRIG_EN
      force_trig = force_mode ? t_arr[i] : 1'b0;
`endif
      rd_en = 1'($urandom_range(0, 1));
      if (i == bogus_i) begin
        start   = 1'b1;
        pre_len = ~DL2'(p);
      end
      step();
      start = 1'b0;
      if (rd_valid) vcnt++;
      if (done) begin
        n = i + 1;
        break;
      end
    end
    trig  = 1'b0;
    rd_en = 1'b0;
`ifdef CAPTURE_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    chk({name, "_writes"}, n, exp_writes);
    chk({name, "_trig_addr"}, int'(trig_addr), exp_ta);
    chk({name, "_busy_rdv"}, int'({busy, 1'(vcnt != 0)}), 0);
    do_readout(name);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    pre_len    = '0;
    sample_in  = '0;
    trig       = 1'b0;
    rd_en      = 1'b0;
    force_mode = 1'b0;
`ifdef CAPTURE_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif

    vecs[0] = '{4,  20, 20, 4,  16, 32};
    vecs[1] = '{0,  0,  0,  0,  0,  16};
    vecs[2] = '{15, 40, 40, 8,  25, 41};
    vecs[3] = '{4,  0,  4,  4,  0,  16};
    vecs[4] = '{15, 15, 15, 15, 0,  16};
    vecs[5] = '{1,  3,  5,  3,  2,  18};

    step();
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_last", int'(rd_last), 0);
    chk("reset_trig_addr", int'(trig_addr), 0);
    rst = 1'b0;

    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_rd_valid", int'(rd_valid), 0);
    end
    rd_en = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NS; i++) begin
        s_arr[i] = 8'(i);
        t_arr[i] = (i >= vecs[v].tlo) && (i <= vecs[v].thi);
      end
      for (int j = 0; j < DEPTH; j++) exp_rd[j] = 8'(vecs[v].exp_first + j);
      do_capture($sformatf("vec%0d", v), vecs[v].pre, -1, vecs[v].exp_ta, vecs[v].exp_writes);
    end

    // A second start while busy must neither restart nor relatch pre_len.
    for (int i = 0; i < NS; i++) begin
      s_arr[i] = 8'(i);
      t_arr[i] = (i == 10);
    end
    for (int j = 0; j < DEPTH; j++) exp_rd[j] = 8'(8 + j);
    do_capture("busy_start", 2, 5, 10, 24);

    // Reset while in POST aborts immediately; reads in IDLE are ignored.
    start   = 1'b1;
    pre_len = 4'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample_in = 8'(i);
      trig      = (i == 6);
      step();
    end
    trig = 1'b0;
    chk("post_busy", int'({busy, done}), 2);
    chk("post_trig_addr", int'(trig_addr), 6);
    rst   = 1'b1;
    rd_en = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst", int'({busy, done, rd_valid, rd_last, trig_addr}), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rd_valid", int'({busy, done, rd_valid}), 0);
    end
    rd_en = 1'b0;

    for (int r = 0; r < 8; r++) begin
      int p;
      int k;
      p = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < NS; i++) begin
        s_arr[i] = 8'($urandom);
        t_arr[i] = ($urandom_range(0, 5) == 0);
      end
      t_arr[p + 40] = 1'b1;
      k = -1;
      for (int i = p; i < NS && k < 0; i++) if (t_arr[i]) k = i;
      for (int j = 0; j < DEPTH; j++) exp_rd[j] = s_arr[k - p + j];
      do_capture($sformatf("rand%0d", r), p, -1, k % DEPTH, k + DEPTH - p);
    end

    // Reset during readout drops the in-flight read.
    rd_en = 1'b1;
    step();
    chk("rdout_valid", int'(rd_valid), 1);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    rd_en = 1'b0;
    chk("rdout_rst", int'({rd_valid, done, busy}), 0);

`ifdef CAPTURE_FORCE_TRIG_EN
    force_mode = 1'b1;
    for (int i = 0; i < NS; i++) begin
      s_arr[i] = 8'(i);
      t_arr[i] = (i == 12);
    end
    for (int j = 0; j < DEPTH; j++) exp_rd[j] = 8'(9 + j);
    do_capture("force", 3, -1, 12, 25);
    force_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
